// File: rtl/secuenciador_temp_teclado_if.sv
// Bus between the PS/2 byte receiver, the entry sequencer and DecoTemps.
// master: byte source / output observer. slave: the sequencer itself.
interface secuenciador_temp_teclado_if;
  logic [7:0] rx_dato;
  logic       rx_listo;
  logic [7:0] DECENAS;
  logic [7:0] UNIDADES;
  logic       dato_valido;
  logic       captura;
  logic       error;
  logic [1:0] estado;

  modport master (
    output rx_dato, rx_listo,
    input  DECENAS, UNIDADES, dato_valido, captura, error, estado
  );

  modport slave (
    input  rx_dato, rx_listo,
    output DECENAS, UNIDADES, dato_valido, captura, error, estado
  );
endinterface

// File: rtl/secuenciador_temp_teclado.sv
// Two-digit temperature entry sequencer: PS/2 scancodes in, committed
// tens/units scancodes plus commit strobe out to DecoTemps.
// Optional feature macro: ENTRY_TIMEOUT_EN (aborts an idle partial entry).
module secuenciador_temp_teclado #(
  parameter int unsigned TIMEOUT_CICLOS = 500_000_000,
  parameter int unsigned CNT_W          = 29,
  parameter logic [7:0]  SC_ENTER       = 8'h5A,
  parameter logic [7:0]  SC_BKSP        = 8'h66,
  parameter logic [7:0]  SC_ESC         = 8'h76
) (
  input logic                         CLK,
  input logic                         reset,
  secuenciador_temp_teclado_if.slave  bus
);

  localparam logic [7:0] SC_CERO  = 8'h45;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  typedef enum logic [1:0] {
    StDec     = 2'b00,
    StUni     = 2'b01,
    StEnter   = 2'b10,
    StIllegal = 2'b11
  } state_e;

  // Elaboration-time sanity check on the timeout counter sizing.
  if (64'(TIMEOUT_CICLOS) >= (64'd1 << CNT_W)) begin : g_cnt_w_check
    $error("CNT_W too small for TIMEOUT_CICLOS");
  end

  state_e     state_q, state_d;
  logic       brk_q, brk_d;
  logic       ext_q, ext_d;
  logic [7:0] pend_dec_q, pend_dec_d;
  logic [7:0] pend_uni_q, pend_uni_d;
  logic [7:0] dec_q, dec_d;
  logic [7:0] uni_q, uni_d;
  logic       valido_q, valido_d;
  logic       captura_q, captura_d;
  logic       error_q, error_d;

`ifdef ENTRY_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CICLOS - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  function automatic logic is_digit(input logic [7:0] b);
    case (b)
      8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
      8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46: is_digit = 1'b1;
      default:                           is_digit = 1'b0;
    endcase
  endfunction

  // State register: all sequential state, async active-low reset.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q    <= StDec;
      brk_q      <= 1'b0;
      ext_q      <= 1'b0;
      pend_dec_q <= SC_CERO;
      pend_uni_q <= SC_CERO;
      dec_q      <= SC_CERO;
      uni_q      <= SC_CERO;
      valido_q   <= 1'b0;
      captura_q  <= 1'b0;
      error_q    <= 1'b0;
`ifdef ENTRY_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      brk_q      <= brk_d;
      ext_q      <= ext_d;
      pend_dec_q <= pend_dec_d;
      pend_uni_q <= pend_uni_d;
      dec_q      <= dec_d;
      uni_q      <= uni_d;
      valido_q   <= valido_d;
      captura_q  <= captura_d;
      error_q    <= error_d;
`ifdef ENTRY_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  // Next-state: byte filter, entry FSM and optional idle timeout.
  always_comb begin
    state_d    = state_q;
    brk_d      = brk_q;
    ext_d      = ext_q;
    pend_dec_d = pend_dec_q;
    pend_uni_d = pend_uni_q;
    dec_d      = dec_q;
    uni_d      = uni_q;
    valido_d   = valido_q;
    captura_d  = 1'b0;
    error_d    = 1'b0;

    if (state_q == StIllegal) begin
      state_d = StDec;
    end else if (bus.rx_listo) begin
      if (brk_q) begin
        // Key released: drop the make code that follows F0.
        brk_d = 1'b0;
        ext_d = 1'b0;
      end else if (bus.rx_dato == SC_BREAK) begin
        brk_d = 1'b1;
        ext_d = 1'b0;
      end else if (bus.rx_dato == SC_EXT) begin
        ext_d = 1'b1;
      end else if (ext_q) begin
        // Extended keys (arrows, keypad Enter...) are never valid input.
        ext_d = 1'b0;
      end else if (bus.rx_dato == SC_ESC) begin
        state_d    = StDec;
        pend_dec_d = SC_CERO;
        pend_uni_d = SC_CERO;
      end else begin
        case (state_q)
          StDec: begin
            if (is_digit(bus.rx_dato)) begin
              pend_dec_d = bus.rx_dato;
              state_d    = StUni;
            end else if (bus.rx_dato != SC_ENTER && bus.rx_dato != SC_BKSP) begin
              error_d = 1'b1;
            end
          end
          StUni: begin
            if (is_digit(bus.rx_dato)) begin
              pend_uni_d = bus.rx_dato;
              state_d    = StEnter;
            end else if (bus.rx_dato == SC_BKSP) begin
              state_d = StDec;
            end else begin
              error_d = 1'b1;
            end
          end
          StEnter: begin
            if (bus.rx_dato == SC_ENTER) begin
              dec_d     = pend_dec_q;
              uni_d     = pend_uni_q;
              valido_d  = 1'b1;
              captura_d = 1'b1;
              state_d   = StDec;
            end else if (bus.rx_dato == SC_BKSP) begin
              state_d = StUni;
            end else begin
              error_d = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end

`ifdef ENTRY_TIMEOUT_EN
    // A strobe in the expiry cycle wins: the counter only runs when idle.
    cnt_d = '0;
    if (!bus.rx_listo && (state_q == StUni || state_q == StEnter)) begin
      if (cnt_q == TIMEOUT_LIM) begin
        state_d    = StDec;
        error_d    = 1'b1;
        pend_dec_d = SC_CERO;
        pend_uni_d = SC_CERO;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
`endif
  end

  // Outputs: straight from registers, glitch-free toward DecoTemps.
  always_comb begin
    bus.DECENAS     = dec_q;
    bus.UNIDADES    = uni_q;
    bus.dato_valido = valido_q;
    bus.captura     = captura_q;
    bus.error       = error_q;
    bus.estado      = state_q;
  end

endmodule
